// File: rtl/tile_vram_ctrl_pkg.sv
// rtl/tile_vram_ctrl_pkg.sv - shared types and constants for the tile VRAM controller
//
// Purpose: tile word layout, host opcode encoding, controller state encoding
// and the default screen geometry.
// Ports: none (package).
package tile_vram_pkg;

  localparam int TILE_COLS = 128;
  localparam int TILE_ROWS = 32;

  typedef struct packed {
    logic [3:0]  fg_color_idx;
    logic [11:0] tile_idx;
  } tile_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_FILL   = 2'd1,
    OP_SCROLL = 2'd2,
    OP_RSVD   = 2'd3
  } vram_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_COPY  = 2'd2,
    ST_CLEAR = 2'd3
  } vram_state_t;

endpackage

// File: rtl/tile_vram_ctrl_if.sv
// rtl/tile_vram_ctrl_if.sv - host command valid/ready bundle
//
// Purpose: groups the host command handshake so the loader and the
// controller connect through one port.
// Signals: host_valid, host_op, host_addr, host_data (master -> slave),
//          host_ready (slave -> master).
interface tile_vram_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  import tile_vram_pkg::*;

  logic              host_valid;
  logic              host_ready;
  vram_op_t          host_op;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (
    output host_valid, host_op, host_addr, host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_op, host_addr, host_data,
    output host_ready
  );

endinterface

// File: rtl/tile_vram_ctrl_copy_pipe.sv
// rtl/tile_vram_ctrl_copy_pipe.sv - two-stage VRAM read-to-write pipeline for scroll copy
//
// Purpose: carries each issued scroll read through the one-cycle VRAM read
// latency and presents it as a write one row up.
// Ports: clk_pix, rst_n          - clock, synchronous active-low reset
//        issue_i, src_i          - read issued this cycle at source address
//        rdata_i                 - VRAM read data (valid one cycle after issue)
//        we_o, waddr_o, din_o    - registered write to src - COLS
//        empty_o                 - no read is left that has yet to reach the write stage
module tile_vram_copy_pipe #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int COLS   = 128
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] din_o,
  output logic              empty_o
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  // Stage 1: read in flight, destination already computed.
  logic              v1_q;
  logic [ADDR_W-1:0] a1_q;
  // Stage 2: write presented to VRAM.
  logic              v2_q;
  logic [ADDR_W-1:0] a2_q;
  logic [DATA_W-1:0] d2_q;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      v2_q <= 1'b0;
      a2_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= issue_i;
      a1_q <= src_i - COLS_A;
      v2_q <= v1_q;
      if (v1_q) begin
        a2_q <= a1_q;
        d2_q <= rdata_i;
      end
    end
  end

  assign we_o    = v2_q;
  assign waddr_o = a2_q;
  assign din_o   = d2_q;
  // The write stage itself finishes this cycle, so only stage 1 matters.
  assign empty_o = ~v1_q;

endmodule

// File: rtl/tile_vram_ctrl.sv
// rtl/tile_vram_ctrl.sv - tile VRAM write-port owner and read-port arbiter
//
// Purpose: executes host WRITE / FILL / SCROLL commands against the tile VRAM,
// borrowing the read port from the display only during vertical blanking.
// Ports: clk_pix, rst_n       - pixel clock, synchronous active-low reset
//        vblank               - read port may be borrowed while high
//        disp_raddr           - display fetch read address
//        host                 - command handshake (slave side)
//        busy, done           - long command in progress / completion pulse
//        vram_raddr, vram_dout - VRAM read port
//        vram_we, vram_waddr, vram_din - VRAM write port
module tile_vram_ctrl
  import tile_vram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int COLS   = TILE_COLS,
  parameter int ROWS   = TILE_ROWS
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] disp_raddr,
  tile_vram_ctrl_if.slave   host,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [DATA_W-1:0] vram_dout,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_din
);

  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] CLEAR_BASE  = ADDR_W'((ROWS - 1) * COLS);

  vram_state_t       state_q;
  logic              we_q;
  logic              done_q;
  logic [ADDR_W-1:0] waddr_q;
  // Holds WRITE data, then the fill value for FILL and for the scroll's CLEAR.
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] src_q;
  logic              issued_all_q;

  logic              accept;
  logic              issue;
  logic [ADDR_W-1:0] seq_end;
  logic              pipe_we;
  logic              pipe_empty;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_din;

  assign host.host_ready = rst_n && (state_q == ST_IDLE);
  assign accept          = host.host_valid && host.host_ready;
  assign issue           = (state_q == ST_COPY) && vblank && !issued_all_q;
  // FILL sweeps the whole address space; CLEAR stops at the last screen word.
  assign seq_end         = (state_q == ST_FILL) ? ADDR_MAX : SCREEN_LAST;

  tile_vram_copy_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COLS   (COLS)
  ) u_copy_pipe (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .issue_i (issue),
    .src_i   (src_q),
    .rdata_i (vram_dout),
    .we_o    (pipe_we),
    .waddr_o (pipe_waddr),
    .din_o   (pipe_din),
    .empty_o (pipe_empty)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      waddr_q      <= '0;
      din_q        <= '0;
      src_q        <= COLS_A;
      issued_all_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            unique case (host.host_op)
              OP_WRITE: begin
                we_q    <= 1'b1;
                waddr_q <= host.host_addr;
                din_q   <= host.host_data;
                done_q  <= 1'b1;
              end
              OP_FILL: begin
                we_q    <= 1'b1;
                waddr_q <= '0;
                din_q   <= host.host_data;
                state_q <= ST_FILL;
              end
              OP_SCROLL: begin
                din_q        <= host.host_data;
                src_q        <= COLS_A;
                issued_all_q <= 1'b0;
                state_q      <= ST_COPY;
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        ST_FILL, ST_CLEAR: begin
          // waddr_q is the write being presented this cycle.
          if (waddr_q == seq_end) begin
            state_q <= ST_IDLE;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= waddr_q + ADDR_ONE;
            done_q  <= (waddr_q == seq_end - ADDR_ONE);
          end
        end
        ST_COPY: begin
          if (issue) begin
            if (src_q == SCREEN_LAST) issued_all_q <= 1'b1;
            else                      src_q        <= src_q + ADDR_ONE;
          end
          // Pipe's final write is on the port now; CLEAR's first write follows directly.
          if (issued_all_q && pipe_empty) begin
            state_q <= ST_CLEAR;
            we_q    <= 1'b1;
            waddr_q <= CLEAR_BASE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign vram_raddr = issue ? src_q : disp_raddr;
  // Copy writes and controller writes never overlap in time.
  assign vram_we    = we_q | pipe_we;
  assign vram_waddr = pipe_we ? pipe_waddr : waddr_q;
  assign vram_din   = pipe_we ? pipe_din : din_q;

endmodule

// File: tb/tb_tile_vram_ctrl.sv
// tb/tb_tile_vram_ctrl.sv - directed self-checking bench for tile_vram_ctrl
module tb_tile_vram_ctrl;
  import tile_vram_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk_pix = 1'b0;
  logic          rst_n;
  logic          vblank = 1'b1;
  logic [AW-1:0] disp_raddr = '0;
  logic          busy, done, vram_we;
  logic [AW-1:0] vram_raddr, vram_waddr;
  logic [DW-1:0] vram_dout, vram_din;

  always #5 clk_pix = ~clk_pix;

  tile_vram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

  tile_vram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .COLS(128), .ROWS(32)) dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .vblank     (vblank),
    .disp_raddr (disp_raddr),
    .host       (host),
    .busy       (busy),
    .done       (done),
    .vram_raddr (vram_raddr),
    .vram_dout  (vram_dout),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_din   (vram_din)
  );

  // VRAM model: synchronous write, one-cycle read latency.
  logic [DW-1:0] mem [0:4095];
  logic          preload = 1'b0;

  function automatic logic [15:0] pat(input int a);
    return 16'((a * 37) ^ 16'h1234);
  endfunction

  always @(posedge clk_pix) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++) mem[a] <= pat(a);
    end else if (vram_we) begin
      mem[vram_waddr] <= vram_din;
    end
    vram_dout <= mem[vram_raddr];
  end

  // Display address sweep and vblank generator.
  logic vb_toggle = 1'b0;
  logic vb_state  = 1'b1;
  int   vb_cnt    = 0;
  always begin
    @(posedge clk_pix);
    #2;
    disp_raddr = disp_raddr + 12'd13;
    if (vb_toggle) begin
      vb_cnt++;
      if (vb_cnt >= 50) begin
        vb_cnt   = 0;
        vb_state = ~vb_state;
      end
      vblank = vb_state;
    end else begin
      vblank = 1'b1;
    end
  end

  // Write / done / read-port monitor.
  int            clr_gen = 0;
  int            clr_seen = 0;
  int            wr_cnt = 0, done_cnt = 0, dbl_done = 0, bad_addr = 0, bad_din = 0, viol = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  logic          seq_chk = 1'b0;
  logic          done_prev = 1'b0;

  always @(negedge clk_pix) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      wr_cnt   = 0;
      done_cnt = 0;
      dbl_done = 0;
      bad_addr = 0;
      bad_din  = 0;
      viol     = 0;
      exp_addr = '0;
    end
    if (vram_we === 1'b1) begin
      wr_cnt++;
      if (seq_chk) begin
        if (vram_waddr !== exp_addr) bad_addr++;
        if (vram_din !== exp_din) bad_din++;
        exp_addr = exp_addr + 12'd1;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) dbl_done++;
    end
    done_prev = (done === 1'b1);
    if (vblank === 1'b0 && vram_raddr !== disp_raddr) viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d);
    host.host_valid = 1'b1;
    host.host_op    = vram_op_t'(op);
    host.host_addr  = a;
    host.host_data  = d;
    #1;
    chk("ready_at_issue", {31'd0, host.host_ready}, 32'd1);
    @(posedge clk_pix);
    @(negedge clk_pix);
    host.host_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk_pix);
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  function automatic int scroll_errs(input logic [15:0] fillv);
    int e = 0;
    for (int a = 0; a < 4096; a++) begin
      if (a < 3968) begin
        if (mem[a] !== pat(a + 128)) e++;
      end else begin
        if (mem[a] !== fillv) e++;
      end
    end
    return e;
  endfunction

  int cyc;

  initial begin
    rst_n           = 1'b0;
    host.host_valid = 1'b0;
    host.host_op    = OP_WRITE;
    host.host_addr  = '0;
    host.host_data  = '0;
    repeat (3) @(negedge clk_pix);
    chk("ready_in_reset", {31'd0, host.host_ready}, 32'd0);
    chk("we_in_reset", {31'd0, vram_we}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("ready_after_release", {31'd0, host.host_ready}, 32'd1);
    chk("reset_we", {31'd0, vram_we}, 32'd0);
    chk("reset_waddr", {20'd0, vram_waddr}, 32'h0);
    chk("reset_din", {16'd0, vram_din}, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_pix);

    // Single WRITE.
    send(2'd0, 12'h085, 16'h0F41);
    chk("write_we", {31'd0, vram_we}, 32'd1);
    chk("write_waddr", {20'd0, vram_waddr}, 32'h085);
    chk("write_din", {16'd0, vram_din}, 32'h0F41);
    chk("write_done", {31'd0, done}, 32'd1);
    chk("write_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_pix);
    chk("write_we_drop", {31'd0, vram_we}, 32'd0);
    chk("write_done_drop", {31'd0, done}, 32'd0);

    // Four back-to-back WRITEs.
    for (int i = 0; i < 4; i++) begin
      host.host_valid = 1'b1;
      host.host_op    = OP_WRITE;
      host.host_addr  = 12'h200 + 12'(i);
      host.host_data  = 16'hA000 + 16'(i);
      #1;
      chk("b2b_ready", {31'd0, host.host_ready}, 32'd1);
      if (i > 0) begin
        chk("b2b_we", {31'd0, vram_we}, 32'd1);
        chk("b2b_waddr", {20'd0, vram_waddr}, 32'h200 + 32'(i - 1));
      end
      @(posedge clk_pix);
      @(negedge clk_pix);
    end
    host.host_valid = 1'b0;
    chk("b2b_last_we", {31'd0, vram_we}, 32'd1);
    chk("b2b_last_waddr", {20'd0, vram_waddr}, 32'h203);
    chk("b2b_last_din", {16'd0, vram_din}, 32'hA003);
    @(negedge clk_pix);
    chk("b2b_we_drop", {31'd0, vram_we}, 32'd0);
    chk("b2b_mem", {16'd0, mem[12'h201]}, 32'hA001);

    // Reserved opcode: done without a write.
    send(2'd3, 12'h300, 16'hDEAD);
    chk("rsvd_done", {31'd0, done}, 32'd1);
    chk("rsvd_we", {31'd0, vram_we}, 32'd0);
    @(negedge clk_pix);
    chk("rsvd_done_drop", {31'd0, done}, 32'd0);

    // FILL.
    clr_gen++;
    seq_chk = 1'b1;
    exp_din = 16'h0720;
    send(2'd1, 12'h000, 16'h0720);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    chk("fill_ready_low", {31'd0, host.host_ready}, 32'd0);
    wait_done(6000, cyc);
    chk("fill_cycles", 32'(cyc), 32'd4096);
    chk("fill_done_waddr", {20'd0, vram_waddr}, 32'hFFF);
    chk("fill_done_we", {31'd0, vram_we}, 32'd1);
    @(negedge clk_pix);
    seq_chk = 1'b0;
    chk("fill_busy_fall", {31'd0, busy}, 32'd0);
    chk("fill_writes", 32'(wr_cnt), 32'd4096);
    chk("fill_bad_addr", 32'(bad_addr), 32'd0);
    chk("fill_bad_din", 32'(bad_din), 32'd0);
    chk("fill_dbl_done", 32'(dbl_done), 32'd0);

    // SCROLL, vblank always high.
    preload = 1'b1;
    @(negedge clk_pix);
    preload = 1'b0;
    clr_gen++;
    send(2'd2, 12'h000, 16'h0B0B);
    chk("scroll_busy", {31'd0, busy}, 32'd1);
    wait_done(10000, cyc);
    chk("scroll_cycles", 32'(cyc), 32'd4098);
    @(negedge clk_pix);
    chk("scroll_busy_fall", {31'd0, busy}, 32'd0);
    chk("scroll_writes", 32'(wr_cnt), 32'd4096);
    chk("scroll_done_cnt", 32'(done_cnt), 32'd1);
    chk("scroll_mem_row0", {16'd0, mem[0]}, {16'd0, pat(128)});
    chk("scroll_mem_row30", {16'd0, mem[3967]}, {16'd0, pat(4095)});
    chk("scroll_mem_row31", {16'd0, mem[3968]}, 32'h0B0B);
    chk("scroll_mem_errs", 32'(scroll_errs(16'h0B0B)), 32'd0);

    // SCROLL with vblank toggling every 50 cycles.
    preload = 1'b1;
    @(negedge clk_pix);
    preload   = 1'b0;
    vb_toggle = 1'b1;
    clr_gen++;
    send(2'd2, 12'h000, 16'h0B0B);
    wait_done(20000, cyc);
    @(negedge clk_pix);
    vb_toggle = 1'b0;
    chk("toggle_paused", {31'd0, cyc > 4098}, 32'd1);
    chk("toggle_raddr_viol", 32'(viol), 32'd0);
    chk("toggle_writes", 32'(wr_cnt), 32'd4096);
    chk("toggle_done_cnt", 32'(done_cnt), 32'd1);
    chk("toggle_mem_errs", 32'(scroll_errs(16'h0B0B)), 32'd0);

    // Reset during COPY.
    repeat (2) @(negedge clk_pix);
    clr_gen++;
    send(2'd2, 12'h000, 16'h1111);
    repeat (100) @(negedge clk_pix);
    chk("midcopy_busy", {31'd0, busy}, 32'd1);
    chk("midcopy_we", {31'd0, vram_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk_pix);
    chk("abort_we", {31'd0, vram_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, host.host_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_pix);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    send(2'd0, 12'h123, 16'hBEEF);
    chk("post_abort_we", {31'd0, vram_we}, 32'd1);
    chk("post_abort_waddr", {20'd0, vram_waddr}, 32'h123);
    chk("post_abort_din", {16'd0, vram_din}, 32'hBEEF);
    chk("post_abort_done", {31'd0, done}, 32'd1);
    @(negedge clk_pix);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_vram_ctrl.md
# tile_vram_ctrl

Owner of the tile VRAM write port and arbiter of its read port. It serves host commands through a valid/ready interface: single word write, whole-screen fill, and one-row scroll-up with a cleared bottom row. The scroll copy reads VRAM, so it borrows the read port from the display fetch path only during vertical blanking. It sits between the host/loader logic and the dual-port tile `block_ram` in the video top level, in the `clk_pix` domain.

## Interface
- `ADDR_W`, 12: VRAM address width; address = {row[4:0], col[6:0]}.
- `DATA_W`, 16: VRAM word width (`tile_t`: fg_color_idx, tile_idx).
- `COLS`, 128: row stride in words.
- `ROWS`, 32: rows in VRAM.
- `clk_pix` in 1: pixel clock. All logic is in this single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `vblank` in 1: high during vertical blanking. The block may take the read port only while this is high.
- `disp_raddr` in ADDR_W: tile read address from the display pipeline.
- `host_valid` in 1: command valid.
- `host_ready` out 1: command accepted on any edge where valid && ready.
- `host_op` in 2: 0 WRITE, 1 FILL, 2 SCROLL, 3 reserved.
- `host_addr` in ADDR_W: word address. Used by WRITE only.
- `host_data` in DATA_W: write data for WRITE; fill value for FILL and SCROLL.
- `busy` out 1: a FILL or SCROLL is in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `vram_raddr` out ADDR_W: driven to the VRAM read port.
- `vram_dout` in DATA_W: VRAM read data, valid 1 cycle after address.
- `vram_we` out 1: VRAM write enable.
- `vram_waddr` out ADDR_W: VRAM write address.
- `vram_din` out DATA_W: VRAM write data.

## Operation
- States: IDLE, FILL, COPY, CLEAR. `host_ready` = rst_n && state==IDLE.
- WRITE accepted in IDLE:
  - Next cycle: `vram_we`=1, `vram_waddr`=host_addr, `vram_din`=host_data, `done`=1.
  - State stays IDLE, so back-to-back writes sustain 1 per cycle.
- Reserved op: accepted; next cycle `done`=1; no write.
- FILL:
  - IDLE→FILL. Writes host_data (latched at accept) to addresses 0..2^ADDR_W-1, one per cycle, ascending.
  - Runs regardless of `vblank`.
  - After the last write: →IDLE, with `done` in the same cycle as the last `vram_we`.
- SCROLL:
  - IDLE→COPY. Source pointer src runs from COLS to ROWS*COLS-1.
  - Each issue cycle: `vram_raddr`=src. Data is written to src-COLS.
  - A read issues only when vblank=1; otherwise src holds (pause).
  - When the last source has issued and all writes have drained: →CLEAR.
  - CLEAR writes the latched value to (ROWS-1)*COLS..ROWS*COLS-1, one per cycle, regardless of `vblank`. Then →IDLE with `done` on the last write.
- Read-port mux (combinational): `vram_raddr` = src when (state==COPY && vblank && issuing), else `disp_raddr`. Display read latency is unchanged.
- `busy` = state != IDLE.
- Address arithmetic is unsigned ADDR_W. src-COLS never underflows because src ≥ COLS. The FILL counter ends at the all-ones address with no wrap.
- Host commands are not queued. `host_valid` during busy waits with ready low.

## Timing
- Reset values: `vram_we`=0, `vram_waddr`=0, `vram_din`=0, `done`=0, `busy`=0, state=IDLE. `host_ready`=0 while rst_n=0 and 1 on the first cycle after release.
- WRITE latency: accept edge → `vram_we` the next cycle.
- COPY pipeline:
  - Cycle c: read issued.
  - c+1: `vram_dout` valid, captured into output registers.
  - c+2: `vram_we`=1 with waddr = src-COLS.
  - Two per-stage valid bits track the in-flight reads.
- `vblank` falls mid-COPY: no new reads from that cycle. Up to 2 in-flight writes still complete. Resumes on the next high `vblank` with no lost or duplicated word.
- `vblank` high continuously: COPY takes (ROWS-1)*COLS + 2 cycles.
- FILL takes 2^ADDR_W cycles. CLEAR takes COLS cycles.
- Reset mid-operation: abort immediately to reset values. VRAM is left partially updated; no `done` pulse.
- `done` is never asserted for more than one cycle.

## Structure
- Package `tile_vram_pkg` holds:
  - `tile_t`
  - enum `vram_op_t` {OP_WRITE, OP_FILL, OP_SCROLL, OP_RSVD}
  - state enum
  - constants TILE_COLS=128, TILE_ROWS=32
- One sub-module: `tile_vram_copy_pipe`, the 2-stage read-to-write pipeline. It takes an issue strobe and src address and produces we/waddr/din plus an empty flag.

## Test plan
- Reset release → host_ready=1, vram_we=0. WRITE addr 0x085 data 0x0F41 → next cycle vram_we=1, waddr=0x085, din=0x0F41, done=1.
- 4 back-to-back WRITEs → 4 consecutive vram_we cycles, ready held high.
- FILL data 0x0720 → 4096 writes 0x000..0xFFF; done on the 0xFFF write; busy falls the next cycle.
- SCROLL with model VRAM, vblank always 1:
  - Row r takes old row r+1 for r=0..30.
  - Row 31 = host_data.
  - Total writes: 3968+128.
- SCROLL with vblank toggling every 50 cycles:
  - No vram_raddr≠disp_raddr while vblank=0.
  - Final memory equals the always-vblank result.
- rst_n low mid-COPY → next cycle vram_we=0, busy=0, no done. A new WRITE is accepted afterwards.
